// File: rtl/maxpool_seq_ctrl_if.sv
// Control/status bundle between the max-pool sequencer and its host, ROM, RAM and pool datapath.
// The sequencer takes the slave side; whoever drives start/abort takes the master side.
interface maxpool_seq_ctrl_if #(
    parameter int unsigned NUM_CH = 8
) ();
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              thre_en;
    logic [2:0]        thre_addr;
    logic [NUM_CH-1:0] thre_load;
    logic              ram_ena;
    logic [7:0]        ram_addr;
    logic [1:0]        phase;
    logic              pool_valid;
    logic [1:0]        pool_phase;
    logic              bin_valid;

    modport master (
        output start, abort,
        input  busy, done, thre_en, thre_addr, thre_load, ram_ena, ram_addr, phase,
        input  pool_valid, pool_phase, bin_valid
    );

    modport slave (
        input  start, abort,
        output busy, done, thre_en, thre_addr, thre_load, ram_ena, ram_addr, phase,
        output pool_valid, pool_phase, bin_valid
    );
endinterface

// File: rtl/maxpool_seq_ctrl.sv
// Layer sequencer for the binarised max-pool stage: loads channel thresholds once, then sweeps
// the activation RAM four window phases per word and drains the compare/binarise pipeline.
module maxpool_seq_ctrl #(
    parameter int unsigned NUM_WORDS = 226,
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned DRAIN_CYC = 2
) (
    input logic               clk,
    input logic               rst_n,
    maxpool_seq_ctrl_if.slave bus
);

    if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_chk_words
        $error("NUM_WORDS must be in 1..256");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_ch
        $error("NUM_CH must be in 1..8");
    end
    if (DRAIN_CYC < 1) begin : g_chk_drain
        $error("DRAIN_CYC must be at least 1");
    end

    localparam int unsigned DrainW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYC - 1);
    localparam logic [7:0] LastAddr   = 8'(NUM_WORDS - 1);
    localparam logic [2:0] LastThre   = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadThre,
        StLoadWait,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic                thre_en_q;
    logic [2:0]          thre_addr_q;
    logic [NUM_CH-1:0]   thre_load_q;
    logic                thre_loaded_q;
    logic                ram_ena_q;
    logic [7:0]          ram_addr_q;
    logic [1:0]          phase_q;
    logic                pool_valid_q;
    logic [1:0]          pool_phase_q;
    logic                bin_valid_q;
    logic [DrainW-1:0]   drain_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            thre_en_q     <= 1'b0;
            thre_addr_q   <= '0;
            thre_load_q   <= '0;
            thre_loaded_q <= 1'b0;
            ram_ena_q     <= 1'b0;
            ram_addr_q    <= '0;
            phase_q       <= '0;
            pool_valid_q  <= 1'b0;
            pool_phase_q  <= '0;
            bin_valid_q   <= 1'b0;
            drain_cnt_q   <= '0;
        end else begin
            // Datapath alignment: ROM and RAM each have one cycle of read latency.
            pool_valid_q <= ram_ena_q;
            pool_phase_q <= phase_q;
            bin_valid_q  <= pool_valid_q;
            thre_load_q  <= thre_en_q ? (NUM_CH'(1) << thre_addr_q) : '0;
            done_q       <= 1'b0;

            if (bus.abort && state_q != StIdle) begin
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                thre_en_q   <= 1'b0;
                thre_addr_q <= '0;
                thre_load_q <= '0;
                ram_ena_q   <= 1'b0;
                ram_addr_q  <= '0;
                phase_q     <= '0;
                drain_cnt_q <= '0;
                // A partial threshold load cannot be trusted.
                if (state_q == StLoadThre || state_q == StLoadWait) begin
                    thre_loaded_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.start && !bus.abort) begin
                            busy_q <= 1'b1;
                            if (thre_loaded_q) begin
                                state_q   <= StRun;
                                ram_ena_q <= 1'b1;
                            end else begin
                                state_q   <= StLoadThre;
                                thre_en_q <= 1'b1;
                            end
                        end
                    end
                    StLoadThre: begin
                        if (thre_addr_q == LastThre) begin
                            state_q     <= StLoadWait;
                            thre_en_q   <= 1'b0;
                            thre_addr_q <= '0;
                        end else begin
                            thre_addr_q <= thre_addr_q + 3'd1;
                        end
                    end
                    StLoadWait: begin
                        state_q       <= StRun;
                        thre_loaded_q <= 1'b1;
                        ram_ena_q     <= 1'b1;
                    end
                    StRun: begin
                        if (phase_q == 2'd3 && ram_addr_q == LastAddr) begin
                            state_q     <= StDrain;
                            ram_ena_q   <= 1'b0;
                            ram_addr_q  <= '0;
                            phase_q     <= '0;
                            drain_cnt_q <= '0;
                        end else begin
                            phase_q <= phase_q + 2'd1;
                            if (phase_q == 2'd3) begin
                                ram_addr_q <= ram_addr_q + 8'd1;
                            end
                        end
                    end
                    StDrain: begin
                        if (drain_cnt_q == DrainLast) begin
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            drain_cnt_q <= '0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DrainW'(1);
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.thre_en    = thre_en_q;
    assign bus.thre_addr  = thre_addr_q;
    assign bus.thre_load  = thre_load_q;
    assign bus.ram_ena    = ram_ena_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.phase      = phase_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_phase = pool_phase_q;
    assign bus.bin_valid  = bin_valid_q;

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Scoreboard bench for maxpool_seq_ctrl: each start pushes the expected per-cycle ROM, RAM,
// pool, binarise and done events; a negedge monitor pops and compares them as they appear.
module tb_maxpool_seq_ctrl;

    localparam int NWords = 226;
    localparam int NCh    = 8;
    localparam int NDrain = 2;
    localparam int RunLen = NWords * 4;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   loaded = 1'b0;

    exp_t q_thre[$];
    exp_t q_load[$];
    exp_t q_ram[$];
    exp_t q_pool[$];
    exp_t q_bin[$];
    exp_t q_done[$];

    maxpool_seq_ctrl_if #(.NUM_CH(NCh)) bus ();

    maxpool_seq_ctrl #(
        .NUM_WORDS(NWords),
        .NUM_CH   (NCh),
        .DRAIN_CYC(NDrain)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pending();
        return q_thre.size() + q_load.size() + q_ram.size() + q_pool.size() + q_bin.size()
               + q_done.size();
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.thre_en) begin
                if (q_thre.size() == 0) check_eq("thre_en_unexpected", 1, 0);
                else begin
                    e = q_thre.pop_front();
                    check_eq("thre_cyc", cyc, e.cyc);
                    check_eq("thre_addr", bus.thre_addr, e.val);
                end
            end else check_eq("thre_addr_idle", bus.thre_addr, 0);
            if (bus.thre_load != '0) begin
                if (q_load.size() == 0) check_eq("thre_load_unexpected", bus.thre_load, 0);
                else begin
                    e = q_load.pop_front();
                    check_eq("load_cyc", cyc, e.cyc);
                    check_eq("thre_load", bus.thre_load, e.val);
                end
            end
            if (bus.ram_ena) begin
                if (q_ram.size() == 0) check_eq("ram_ena_unexpected", 1, 0);
                else begin
                    e = q_ram.pop_front();
                    check_eq("ram_cyc", cyc, e.cyc);
                    check_eq("ram_addr_phase", {bus.ram_addr, bus.phase}, e.val);
                end
            end else check_eq("ram_idle_addr_phase", {bus.ram_addr, bus.phase}, 0);
            if (bus.pool_valid) begin
                if (q_pool.size() == 0) check_eq("pool_valid_unexpected", 1, 0);
                else begin
                    e = q_pool.pop_front();
                    check_eq("pool_cyc", cyc, e.cyc);
                    check_eq("pool_phase", bus.pool_phase, e.val);
                end
            end
            if (bus.bin_valid) begin
                if (q_bin.size() == 0) check_eq("bin_valid_unexpected", 1, 0);
                else begin
                    e = q_bin.pop_front();
                    check_eq("bin_cyc", cyc, e.cyc);
                end
            end
            if (bus.done) begin
                check_eq("done_busy", bus.busy, 0);
                if (q_done.size() == 0) check_eq("done_unexpected", 1, 0);
                else begin
                    e = q_done.pop_front();
                    check_eq("done_cyc", cyc, e.cyc);
                end
            end
        end
    end

    // Pulse start and queue everything the layer should produce; k is the first busy cycle.
    task automatic start_job(output int k, output int base);
        @(negedge clk);
        k = cyc + 1;
        base = k;
        if (!loaded) begin
            for (int i = 0; i < NCh; i++) begin
                q_thre.push_back('{cyc: k + i, val: i});
                q_load.push_back('{cyc: k + i + 1, val: 1 << i});
            end
            base = k + NCh + 1;
            loaded = 1'b1;
        end
        for (int j = 0; j < RunLen; j++) begin
            q_ram.push_back('{cyc: base + j, val: j});
            q_pool.push_back('{cyc: base + j + 1, val: j % 4});
            q_bin.push_back('{cyc: base + j + 2, val: 0});
        end
        q_done.push_back('{cyc: base + RunLen + NDrain, val: 0});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("busy_after_start", bus.busy, 1);
    endtask

    // Drop expectations the cut-off cycle makes impossible; tail covers the pipeline lag.
    task automatic trim(input int lim, input int tail);
        while (q_thre.size() > 0 && q_thre[$].cyc > lim) void'(q_thre.pop_back());
        while (q_load.size() > 0 && q_load[$].cyc > lim) void'(q_load.pop_back());
        while (q_ram.size() > 0 && q_ram[$].cyc > lim) void'(q_ram.pop_back());
        while (q_pool.size() > 0 && q_pool[$].cyc > lim + tail) void'(q_pool.pop_back());
        while (q_bin.size() > 0 && q_bin[$].cyc > lim + 2 * tail) void'(q_bin.pop_back());
        while (q_done.size() > 0 && q_done[$].cyc > lim) void'(q_done.pop_back());
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_all();
        for (int i = 0; i < 2000 && pending() > 0; i++) @(negedge clk);
        check_eq("drain_timeout_pending", pending(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        int base;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_thre_en", bus.thre_en, 0);
        check_eq("rst_thre_addr", bus.thre_addr, 0);
        check_eq("rst_thre_load", bus.thre_load, 0);
        check_eq("rst_ram_ena", bus.ram_ena, 0);
        check_eq("rst_ram_addr", bus.ram_addr, 0);
        check_eq("rst_phase", bus.phase, 0);
        check_eq("rst_pool_valid", bus.pool_valid, 0);
        check_eq("rst_pool_phase", bus.pool_phase, 0);
        check_eq("rst_bin_valid", bus.bin_valid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First layer loads thresholds, second skips loading.
        start_job(k, base);
        wait_all();
        start_job(k, base);
        check_eq("noload_ram_ena_first", bus.ram_ena, 1);
        wait_all();

        // Abort at RUN index 100 (word 25, phase 0).
        start_job(k, base);
        wait_cyc(base + 100);
        check_eq("abort_point_addr", bus.ram_addr, 25);
        bus.abort = 1'b1;
        trim(base + 100, 1);
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort_ram_ena", bus.ram_ena, 0);
        check_eq("abort_busy", bus.busy, 0);
        wait_all();
        start_job(k, base);
        wait_all();

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("idle_abort_busy", bus.busy, 0);
        check_eq("idle_abort_ram_ena", bus.ram_ena, 0);
        repeat (4) @(negedge clk);

        // Asynchronous reset at word 100.
        start_job(k, base);
        wait_cyc(base + 400);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_ram_ena", bus.ram_ena, 0);
        check_eq("arst_ram_addr", bus.ram_addr, 0);
        check_eq("arst_pool_valid", bus.pool_valid, 0);
        check_eq("arst_bin_valid", bus.bin_valid, 0);
        trim(cyc, 0);
        loaded = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reload after reset, aborted at thre_addr 3; thresholds must not count as loaded.
        start_job(k, base);
        wait_cyc(k + 3);
        check_eq("load_abort_point", bus.thre_addr, 3);
        bus.abort = 1'b1;
        trim(k + 3, 1);
        loaded = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("load_abort_thre_en", bus.thre_en, 0);
        check_eq("load_abort_thre_load", bus.thre_load, 0);
        wait_all();

        // Full reload, with start held for 10 cycles mid-RUN.
        start_job(k, base);
        wait_cyc(base + 50);
        bus.start = 1'b1;
        wait_cyc(base + 60);
        bus.start = 1'b0;
        wait_all();

        check_eq("left_thre", q_thre.size(), 0);
        check_eq("left_ram", q_ram.size(), 0);
        check_eq("left_done", q_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/maxpool_seq_ctrl.md
MAXPOOL_SEQ_CTRL -- requirements
Module: maxpool_seq_ctrl

Interface
REQ-001 Parameter NUM_WORDS, default 226: number of packed 32-bit activation words per channel bank.
REQ-002 Parameter NUM_CH, default 8: number of channels and threshold ROM entries.
REQ-003 Parameter DRAIN_CYC, default 2: cycles from the last RAM read to the last binarised result.
REQ-004 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle request to process one layer.
REQ-008 abort  input  1  synchronous cancel.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 thre_en  output  1  threshold ROM enable.
REQ-012 thre_addr  output  3  threshold ROM address.
REQ-013 thre_load  output  NUM_CH  one-hot load strobe to the per-channel threshold registers.
REQ-014 ram_ena  output  1  activation RAM read enable; write enable is its inverse.
REQ-015 ram_addr  output  8  activation RAM word address.
REQ-016 phase  output  2  in-word window phase, 0..3.
REQ-017 pool_valid  output  1  compare-window input valid.
REQ-018 pool_phase  output  2  phase aligned with pool_valid.
REQ-019 bin_valid  output  1  binarised outputs valid.

Function
REQ-020 FSM states: IDLE, LOAD_THRE, LOAD_WAIT, RUN, DRAIN, DONE.
REQ-021 IDLE with start=1 and abort=0 moves to LOAD_THRE if thre_loaded=0, otherwise to RUN.
REQ-022 start is ignored in every state except IDLE.
REQ-023 LOAD_THRE lasts NUM_CH cycles, with thre_en=1 and thre_addr stepping 0..NUM_CH-1 by one per cycle; after the last address the FSM moves to LOAD_WAIT.
REQ-024 thre_load[k] pulses in the cycle after thre_addr=k, matching the 1-cycle ROM latency; exactly one bit is set per cycle.
REQ-025 LOAD_WAIT lasts 1 cycle, delivers the final thre_load strobe, sets thre_loaded, then moves to RUN.
REQ-026 thre_loaded persists across layers and is cleared only by reset or by an abort taken during LOAD_THRE or LOAD_WAIT.
REQ-027 RUN holds ram_ena=1.
  - phase increments every cycle and wraps 3->0.
  - ram_addr starts at 0 and increments when phase=3.
  - RUN lasts exactly NUM_WORDS*4 cycles.
REQ-028 The last RUN cycle is ram_addr=NUM_WORDS-1 with phase=3; the next state is DRAIN and ram_addr returns to 0.
REQ-029 pool_valid and pool_phase equal the previous cycle's RUN indication and phase, matching the 1-cycle RAM latency.
REQ-030 bin_valid equals pool_valid delayed by 1 cycle, matching the compare register.
REQ-031 DRAIN lasts DRAIN_CYC cycles with ram_enan=0, then moves to DONE.
REQ-032 DONE lasts 1 cycle with done=1 and busy=0 in that cycle, then moves to IDLE.
REQ-033 Outside RUN: ram_ena=0, ram_addr=0, phase=0.
REQ-034 Outside LOAD_THRE: thre_en=0 and thre_addr=0.
REQ-035 abort=1 in any non-IDLE state forces IDLE at the next edge.
  - busy, ram_ena, thre_en and thre_load go to 0 from that edge.
  - pool_valid and bin_valid clear within 2 cycles.
  - done does not pulse.
REQ-036 If start and abort are both 1 in IDLE, abort wins and start is ignored.
REQ-037 ram_addr width is 8 bits; NUM_WORDS is at most 256 and is checked at elaboration.

Reset
REQ-038 Asserting rst_n=0 at any time, including mid-RUN, immediately sets:
  - state=IDLE;
  - busy, done, thre_en, ram_ena, pool_valid and bin_valid to 0;
  - thre_addr, thre_load, ram_addr, phase and pool_phase to 0;
  - thre_loaded to 0.
REQ-039 The first start after reset always performs LOAD_THRE.

Verification
REQ-040 Reset, then a start pulse produces:
  - thre_addr 0..7 on 8 consecutive cycles;
  - thre_load 0x01..0x80 each one cycle later;
  - RUN for 904 cycles;
  - done exactly 906 cycles after RUN entry with the default DRAIN_CYC.
REQ-041 A second start after done skips loading.
  - ram_ena rises the cycle after start.
  - ram_addr=225 with phase=3 on the 904th RUN cycle.
  - No thre_en activity.
REQ-042 abort at RUN cycle 100 (ram_addr=25, phase=0):
  - ram_ena=0 at the next edge;
  - no done pulse;
  - the next start goes straight to RUN.
REQ-043 abort during LOAD_THRE at thre_addr=3 leaves thre_loaded=0, so the next start reissues all 8 ROM addresses.
REQ-044 start held high for 10 cycles during RUN causes no restart: the ram_addr sequence continues monotonically, and exactly one done pulse occurs.
REQ-045 rst_n pulsed low at ram_addr=100 clears all outputs asynchronously, and the next start repeats the full load plus run sequence.
